// File: rtl/rr_selector_pkg.sv
// Shared constants for the round-robin selector: polarity/mode tokens and the
// pointer wrap helper used by the top.
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package rr_selector_pkg;

    localparam bit RR_ENABLE  = 1'b1;
    localparam bit RR_DISABLE = 1'b0;
    localparam bit ACT_HIGH   = 1'b1;
    localparam bit ACT_LOW    = 1'b0;

    // Pointer advances past the winner, wrapping at the last channel.
    function automatic int wrap_inc(input int w, input int n);
        return (w == n - 1) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/rr_selector_pick.sv
// Combinational rotating-priority pick: lowest active index >= ptr, else the
// lowest active index overall.
module rr_pick #(
    parameter int IN    = 8,
    parameter int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic [IN-1:0]    req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [IN-1:0]    onehot
);

    logic [IN-1:0] mask_req;
    logic [IN-1:0] sel;

    always_comb begin
        mask_req = '0;
        for (int i = 0; i < IN; i++) begin
            mask_req[i] = req[i] && (i >= int'(ptr));
        end
        sel = (|mask_req) ? mask_req : req;

        // Scan high to low so the lowest set bit is the last one written.
        idx    = '0;
        onehot = '0;
        for (int i = IN - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
        found = |req;
    end

endmodule

// File: rtl/rr_selector.sv
// Registered priority/round-robin selector with valid/ready output and a
// combinational acknowledge to the winning requester.
module rr_selector
    import rr_selector_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int IN    = 8,
    parameter bit ACT   = `High,
    parameter bit RR    = `Enable,
    parameter int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic [IN-1:0]            req,
    input  logic [IN-1:0][DATA-1:0]  in,
    output logic [IN-1:0]            ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA-1:0]          out,
    output logic [IDX_W-1:0]         out_idx,
    output logic [IN-1:0]            out_pos
);

    logic [IN-1:0]    req_hi;
    logic [IN-1:0]    ack_hi;
    logic             load;
    logic             capture;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IN-1:0]    win_oh;
    logic [IDX_W-1:0] pick_ptr;

    logic [IDX_W-1:0] ptr_d, ptr_q;
    logic             out_valid_d, out_valid_q;
    logic [DATA-1:0]  out_d, out_q;
    logic [IDX_W-1:0] out_idx_d, out_idx_q;
    logic [IN-1:0]    out_pos_d, out_pos_q;

    assign req_hi   = ACT ? req : ~req;
    assign pick_ptr = RR ? ptr_q : '0;

    rr_pick #(
        .IN    (IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_hi),
        .ptr    (pick_ptr),
        .found  (found),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    assign load    = !out_valid_q || out_ready;
    assign capture = load && found;

    // Gate with reset so no requester believes it was served during reset.
    assign ack_hi = (reset_ && capture) ? win_oh : '0;
    assign ack    = ACT ? ack_hi : ~ack_hi;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_idx_d   = out_idx_q;
        out_pos_d   = out_pos_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_d       = in[win_idx];
            out_idx_d   = win_idx;
            out_pos_d   = win_oh;
            if (RR && IN > 1) begin
                ptr_d = IDX_W'(wrap_inc(int'(win_idx), IN));
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_idx_q   <= '0;
            out_pos_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_idx_q   <= out_idx_d;
            out_pos_q   <= out_pos_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_idx   = out_idx_q;
    assign out_pos   = out_pos_q;

endmodule
